// File: rtl/lcd1602_bus_receiver.sv
// LCD1602 (HD44780) bus receiver: snoops controller writes into a
// 32-character buffer and mirrors cursor and configuration state.
module lcd1602_bus_receiver #(
  parameter int         MIN_EN_HIGH = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_idx,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       two_line,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       data_strobe,
  output logic [7:0] last_cmd,
  output logic       addr_err,
  output logic       rd_err,
  output logic       overrun
);

  localparam int CW =
    (MIN_EN_HIGH < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0] MIN_W = CW'(MIN_EN_HIGH);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    DECODE,
    CLEAR
  } state_t;

  state_t        state;
  logic [10:0]   sync1;
  logic [10:0]   sync2;
  logic          rs_s;
  logic          rw_s;
  logic          en_s;
  logic [7:0]    d_s;
  logic [CW-1:0] hi_cnt;
  logic          lat_rs;
  logic          lat_rw;
  logic [7:0]    lat_d;
  logic          fell;
  logic          accept;
  logic [4:0]    clr_idx;
  logic [4:0]    cur_inc;
  logic [4:0]    cur_dec;
  logic [7:0]    mem [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {rs, rw, enable, data};
      sync2 <= sync1;
    end
  end

  assign {rs_s, rw_s, en_s, d_s} = sync2;

  // Width counter runs in every state so a transfer that ends
  // during a clear can still be recognised and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lat_rs <= 1'b0;
      lat_rw <= 1'b0;
      lat_d  <= '0;
    end else if (en_s) begin
      if (hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
      lat_rs <= rs_s;
      lat_rw <= rw_s;
      lat_d  <= d_s;
    end else begin
      hi_cnt <= '0;
    end
  end

  assign fell    = !en_s && (hi_cnt != '0);
  assign accept  = fell && (hi_cnt >= MIN_W);
  assign cur_inc = cursor_idx + 5'd1;
  assign cur_dec = cursor_idx - 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= CLEAR_CHAR;
      state       <= IDLE;
      clr_idx     <= '0;
      cursor_idx  <= '0;
      inc_mode    <= 1'b1;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      busy        <= 1'b0;
      last_cmd    <= '0;
      rd_char     <= '0;
      cmd_strobe  <= 1'b0;
      data_strobe <= 1'b0;
      addr_err    <= 1'b0;
      rd_err      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cmd_strobe  <= 1'b0;
      data_strobe <= 1'b0;
      addr_err    <= 1'b0;
      rd_err      <= 1'b0;
      overrun     <= 1'b0;
      rd_char     <= mem[rd_idx];
      unique case (state)
        IDLE, HIGH: begin
          if (accept)    state <= DECODE;
          else if (en_s) state <= HIGH;
          else           state <= IDLE;
        end
        DECODE: begin
          state <= IDLE;
          if (lat_rw) begin
            rd_err <= 1'b1;
          end else if (lat_rs) begin
            data_strobe     <= 1'b1;
            mem[cursor_idx] <= lat_d;
            cursor_idx      <= inc_mode ? cur_inc : cur_dec;
          end else begin
            cmd_strobe <= 1'b1;
            last_cmd   <= lat_d;
            unique case (1'b1)
              lat_d[7]: begin
                if (lat_d[6:4] == 3'b000 || lat_d[6:4] == 3'b100)
                  cursor_idx <= {lat_d[6], lat_d[3:0]};
                else
                  addr_err <= 1'b1;
              end
              lat_d[7:6] == 2'b01: ;
              lat_d[7:5] == 3'b001: two_line <= lat_d[3];
              lat_d[7:4] == 4'b0001: begin
                if (!lat_d[3])
                  cursor_idx <= lat_d[2] ? cur_inc : cur_dec;
              end
              lat_d[7:3] == 5'b00001: begin
                display_on <= lat_d[2];
                cursor_on  <= lat_d[1];
                blink_on   <= lat_d[0];
              end
              lat_d[7:2] == 6'b000001: inc_mode <= lat_d[1];
              lat_d[7:1] == 7'b0000001: cursor_idx <= '0;
              lat_d == 8'h01: begin
                state   <= CLEAR;
                busy    <= 1'b1;
                clr_idx <= '0;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          mem[clr_idx] <= CLEAR_CHAR;
          clr_idx      <= clr_idx + 5'd1;
          if (accept) overrun <= 1'b1;
          if (clr_idx == 5'd31) begin
            busy       <= 1'b0;
            state      <= IDLE;
            cursor_idx <= '0;
            inc_mode   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// Randomized bench for lcd1602_bus_receiver against a transfer-level
// model of the LCD1602 buffer, cursor and configuration.
module tb_lcd1602_bus_receiver;
  localparam int MIN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rs = 1'b0;
  logic       rw = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] rd_idx = '0;
  logic [7:0] rd_char;
  logic [4:0] cursor_idx;
  logic       display_on, cursor_on, blink_on, inc_mode, two_line;
  logic       busy, cmd_strobe, data_strobe;
  logic [7:0] last_cmd;
  logic       addr_err, rd_err, overrun;

  lcd1602_bus_receiver #(
    .MIN_EN_HIGH(MIN),
    .CLEAR_CHAR (8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs         (rs),
    .rw         (rw),
    .enable     (enable),
    .data       (data),
    .rd_idx     (rd_idx),
    .rd_char    (rd_char),
    .cursor_idx (cursor_idx),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .inc_mode   (inc_mode),
    .two_line   (two_line),
    .busy       (busy),
    .cmd_strobe (cmd_strobe),
    .data_strobe(data_strobe),
    .last_cmd   (last_cmd),
    .addr_err   (addr_err),
    .rd_err     (rd_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_mem [32];
  int         m_cur;
  logic       m_inc, m_disp, m_curs, m_blink, m_two;
  logic [7:0] m_last;
  int e_cmd = 0, e_data = 0, e_aerr = 0, e_rerr = 0, e_ovr = 0;

  // pulse monitor
  int c_cmd = 0, c_data = 0, c_aerr = 0, c_rerr = 0, c_ovr = 0;
  int busy_cycles = 0;
  int wide = 0;
  logic p_cmd = 0, p_data = 0, p_aerr = 0, p_rerr = 0, p_ovr = 0;
  logic [7:0] rbuf [32];

  always @(negedge clk) begin
    if (cmd_strobe)  c_cmd++;
    if (data_strobe) c_data++;
    if (addr_err)    c_aerr++;
    if (rd_err)      c_rerr++;
    if (overrun)     c_ovr++;
    if (busy)        busy_cycles++;
    if ((cmd_strobe && p_cmd) || (data_strobe && p_data) ||
        (addr_err && p_aerr) || (rd_err && p_rerr) ||
        (overrun && p_ovr))
      wide++;
    p_cmd  = cmd_strobe;
    p_data = data_strobe;
    p_aerr = addr_err;
    p_rerr = rd_err;
    p_ovr  = overrun;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0;
    m_inc = 1;
    {m_disp, m_curs, m_blink, m_two} = '0;
    m_last = '0;
  endfunction

  function automatic void model_xfer(input logic r, input logic w,
                                     input logic [7:0] d,
                                     input int width);
    int a;
    if (width < MIN) return;
    if (w) begin
      e_rerr++;
      return;
    end
    if (r) begin
      e_data++;
      m_mem[m_cur] = d;
      m_cur = m_inc ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
      return;
    end
    e_cmd++;
    m_last = d;
    if (d >= 8'h80) begin
      a = int'(d[6:0]);
      if (a < 16) m_cur = a;
      else if (a >= 64 && a < 80) m_cur = a - 64 + 16;
      else e_aerr++;
    end else if (d >= 8'h40) begin
      a = 0;
    end else if (d >= 8'h20) begin
      m_two = d[3];
    end else if (d >= 8'h10) begin
      if (!d[3]) m_cur = d[2] ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
    end else if (d >= 8'h08) begin
      {m_disp, m_curs, m_blink} = d[2:0];
    end else if (d >= 8'h04) begin
      m_inc = d[1];
    end else if (d >= 8'h02) begin
      m_cur = 0;
    end else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0;
      m_inc = 1;
    end
  endfunction

  function automatic logic [18:0] dut_vec();
    return {cursor_idx, inc_mode, display_on, cursor_on, blink_on,
            two_line, last_cmd, busy};
  endfunction

  function automatic logic [18:0] mdl_vec();
    return {5'(m_cur), m_inc, m_disp, m_curs, m_blink, m_two,
            m_last, 1'b0};
  endfunction

  function automatic logic [79:0] cnt_vec();
    return {16'(c_cmd), 16'(c_data), 16'(c_aerr), 16'(c_rerr),
            16'(c_ovr)};
  endfunction

  function automatic logic [79:0] exp_vec();
    return {16'(e_cmd), 16'(e_data), 16'(e_aerr), 16'(e_rerr),
            16'(e_ovr)};
  endfunction

  task automatic xfer(input logic r, input logic w, input logic [7:0] d,
                      input int width, input int gap);
    @(posedge clk);
    #1;
    rs = r;
    rw = w;
    data = d;
    enable = 1'b1;
    repeat (width) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic r, input logic w, input logic [7:0] d,
                      input int width, input int gap);
    xfer(r, w, d, width, gap);
    model_xfer(r, w, d, width);
  endtask

  task automatic read_buf();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_idx = 5'(i);
      @(posedge clk);
      #1;
      rbuf[i] = rd_char;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (dut_vec() !== 19'({5'd0, 1'b1, 4'b0, 8'h00, 1'b0})) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h", dut_vec(),
               19'({5'd0, 1'b1, 4'b0, 8'h00, 1'b0}));
    end
    n_vec++;
    if ({rd_char, cmd_strobe, data_strobe, addr_err, rd_err, overrun}
        !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got rd_char=%h pulses=%b", rd_char,
               {cmd_strobe, data_strobe, addr_err, rd_err, overrun});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== 8'h20) begin
        n_bad++;
        $display("FAIL reset_buf[%0d] got %h want 20", i, rbuf[i]);
      end
    end
  endtask

  task automatic test_init_seq();
    int b0;
    send(0, 0, 8'h38, 2, 6);
    send(0, 0, 8'h0C, 3, 6);
    send(0, 0, 8'h06, 2, 6);
    b0 = busy_cycles;
    send(0, 0, 8'h01, 2, 45);
    n_vec++;
    if (busy_cycles - b0 !== 32) begin
      n_bad++;
      $display("FAIL init_busy_len got %0d want 32", busy_cycles - b0);
    end
    n_vec++;
    if ({two_line, display_on, cursor_on, inc_mode} !== 4'b1101) begin
      n_bad++;
      $display("FAIL init_cfg got %b want 1101",
               {two_line, display_on, cursor_on, inc_mode});
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL init_state got %h want %h", dut_vec(), mdl_vec());
    end
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== m_mem[i]) begin
        n_bad++;
        $display("FAIL init_buf[%0d] got %h want %h", i, rbuf[i],
                 m_mem[i]);
      end
    end
  endtask

  task automatic test_ddram_write();
    send(0, 0, 8'h80, 2, 6);
    send(1, 0, 8'h41, 2, 6);
    send(1, 0, 8'h42, 2, 6);
    n_vec++;
    if (cursor_idx !== 5'd2) begin
      n_bad++;
      $display("FAIL ddram_cur_a got %0d want 2", cursor_idx);
    end
    send(0, 0, 8'h8F, 2, 6);
    send(1, 0, 8'h58, 2, 6);
    send(1, 0, 8'h59, 2, 6);
    n_vec++;
    if (cursor_idx !== 5'd17) begin
      n_bad++;
      $display("FAIL ddram_cur_b got %0d want 17", cursor_idx);
    end
    read_buf();
    n_vec++;
    if ({rbuf[0], rbuf[1], rbuf[15], rbuf[16]} !== 32'h41425859) begin
      n_bad++;
      $display("FAIL ddram_bytes got %h want 41425859",
               {rbuf[0], rbuf[1], rbuf[15], rbuf[16]});
    end
    n_vec++;
    if (cnt_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL ddram_counts got %h want %h", cnt_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap_addr_err();
    int a0;
    send(0, 0, 8'h80, 2, 6);
    send(0, 0, 8'h04, 2, 6);
    send(1, 0, 8'h30, 2, 6);
    n_vec++;
    if (cursor_idx !== 5'd31) begin
      n_bad++;
      $display("FAIL wrap_cur got %0d want 31", cursor_idx);
    end
    a0 = c_aerr;
    send(0, 0, 8'h90, 2, 6);
    n_vec++;
    if ({c_aerr - a0, 32'(cursor_idx), 32'(last_cmd)} !==
        {32'd1, 32'd31, 32'h90}) begin
      n_bad++;
      $display("FAIL addr_err got aerr=%0d cur=%0d last=%h want 1 31 90",
               c_aerr - a0, cursor_idx, last_cmd);
    end
    read_buf();
    n_vec++;
    if (rbuf[0] !== 8'h30) begin
      n_bad++;
      $display("FAIL wrap_byte got %h want 30", rbuf[0]);
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL wrap_state got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_glitch_rw();
    int d0, r0, k0;
    d0 = c_data;
    send(1, 0, 8'h41, 1, 6);
    n_vec++;
    if (c_data !== d0) begin
      n_bad++;
      $display("FAIL glitch_strobe got %0d want %0d", c_data, d0);
    end
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== m_mem[i]) begin
        n_bad++;
        $display("FAIL glitch_buf[%0d] got %h want %h", i, rbuf[i],
                 m_mem[i]);
      end
    end
    r0 = c_rerr;
    k0 = c_cmd;
    send(0, 1, 8'h55, 3, 6);
    n_vec++;
    if ({c_rerr - r0, c_cmd - k0} !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL rd_err got rerr=%0d cmd=%0d want 1 0",
               c_rerr - r0, c_cmd - k0);
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL rw_state got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = c_ovr;
    xfer(0, 0, 8'h01, 2, 2);
    model_xfer(0, 0, 8'h01, 2);
    xfer(1, 0, 8'h55, 2, 40);
    e_ovr++;
    n_vec++;
    if (c_ovr - o0 !== 1) begin
      n_bad++;
      $display("FAIL overrun got %0d want 1", c_ovr - o0);
    end
    n_vec++;
    if (cnt_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL ovr_counts got %h want %h", cnt_vec(), exp_vec());
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL ovr_state got %h want %h", dut_vec(), mdl_vec());
    end
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== 8'h20) begin
        n_bad++;
        $display("FAIL ovr_buf[%0d] got %h want 20", i, rbuf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    send(0, 0, 8'h06, 2, 6);
    send(0, 0, 8'hC4, 2, 6);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send(1, 0, d, 2, (i == 7) ? 6 : 0);
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL b2b_state got %h want %h", dut_vec(), mdl_vec());
    end
    n_vec++;
    if (cnt_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL b2b_counts got %h want %h", cnt_vec(), exp_vec());
    end
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== m_mem[i]) begin
        n_bad++;
        $display("FAIL b2b_buf[%0d] got %h want %h", i, rbuf[i],
                 m_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       r, w;
    logic [7:0] d;
    int         width, gap;
    for (int n = 0; n < 80; n++) begin
      w = ($urandom_range(0, 9) == 0);
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (!r && $urandom_range(0, 2) == 0)
        d = 8'h80 | 8'($urandom_range(0, 8'h4F));
      width = $urandom_range(1, 4);
      gap = (!w && !r && d == 8'h01 && width >= MIN) ? 40 : 6;
      send(r, w, d, width, gap);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL rand_state[%0d] d=%h got %h want %h", n, d,
                 dut_vec(), mdl_vec());
      end
      n_vec++;
      if (cnt_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rand_counts[%0d] got %h want %h", n, cnt_vec(),
                 exp_vec());
      end
    end
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== m_mem[i]) begin
        n_bad++;
        $display("FAIL rand_buf[%0d] got %h want %h", i, rbuf[i],
                 m_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int d0;
    send(1, 0, 8'h77, 2, 6);
    xfer(0, 0, 8'h01, 2, 0);
    for (int k = 0; k < 20 && !busy; k++) begin
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_start got busy=%b want 1", busy);
    end
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    n_vec++;
    if ({busy, cursor_idx, rd_char} !== 14'h0) begin
      n_bad++;
      $display("FAIL mid_reset got busy=%b cur=%0d rd=%h want 0 0 00",
               busy, cursor_idx, rd_char);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    read_buf();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rbuf[i] !== 8'h20) begin
        n_bad++;
        $display("FAIL mid_buf[%0d] got %h want 20", i, rbuf[i]);
      end
    end
    d0 = c_data;
    send(1, 0, 8'h41, 2, 6);
    n_vec++;
    if (c_data - d0 !== 1) begin
      n_bad++;
      $display("FAIL post_reset_strobe got %0d want 1", c_data - d0);
    end
    n_vec++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL post_reset_state got %h want %h", dut_vec(),
               mdl_vec());
    end
    read_buf();
    n_vec++;
    if (rbuf[0] !== 8'h41) begin
      n_bad++;
      $display("FAIL post_reset_byte got %h want 41", rbuf[0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_seq();
    test_ddram_write();
    test_wrap_addr_err();
    test_glitch_rw();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    n_vec++;
    if (wide !== 0) begin
      n_bad++;
      $display("FAIL pulse_width got %0d wide pulses want 0", wide);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
